// File: rtl/conv_pkg.sv
// Shared defaults and helpers for the convolution / pooling stream blocks.
package conv_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LENY  = 5;
  localparam int DEF_POOL  = 2;

  typedef logic signed [DEF_WIDTH-1:0] sample_t;

  // Counter width for a 0..n-1 range; a single-value range still gets one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_WIN_W = cnt_w(DEF_POOL);
  localparam int DEF_FRM_W = cnt_w(DEF_LENY);

endpackage

// File: rtl/maxpool_win_ctl.sv
// Window/frame position tracking and window-close decode for maxpool_1d_stream.
// MAXPOOL_PARTIAL_WIN_EN: when defined, the trailing short window of a frame emits a result.
module maxpool_win_ctl
  import conv_pkg::*;
#(
  parameter int LENY = DEF_LENY,
  parameter int POOL = DEF_POOL
) (
  input  logic clk,
  input  logic reset,
  input  logic accept,
  output logic win_first,
  output logic emit
);

  localparam int WIN_W = cnt_w(POOL);
  localparam int FRM_W = cnt_w(LENY);

  logic [WIN_W-1:0] win_cnt;
  logic [FRM_W-1:0] frm_cnt;
  logic             win_full;
  logic             frm_last;
  logic             win_close;

  assign win_full  = (win_cnt == WIN_W'(POOL - 1));
  assign frm_last  = (frm_cnt == FRM_W'(LENY - 1));
  assign win_first = (win_cnt == '0);
  assign win_close = win_full || frm_last;

`ifdef MAXPOOL_PARTIAL_WIN_EN
  assign emit = win_close;
`else
  // A short trailing window is consumed silently.
  assign emit = win_full;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt <= '0;
      frm_cnt <= '0;
    end else if (accept) begin
      win_cnt <= win_close ? '0 : win_cnt + 1'b1;
      frm_cnt <= frm_last  ? '0 : frm_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/maxpool_1d_stream.sv
// Streaming 1-D signed max-pool (window POOL, stride POOL) over LENY-sample frames.
// MAXPOOL_PARTIAL_WIN_EN: when defined, the trailing partial window of each frame is emitted.
module maxpool_1d_stream
  import conv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LENY  = DEF_LENY,
  parameter int POOL  = DEF_POOL
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic signed [WIDTH-1:0] m_data_out,
  output logic                    m_valid,
  input  logic                    m_ready
);

  typedef logic signed [WIDTH-1:0] data_t;

  function automatic data_t smax(input data_t a, input data_t b);
    return (a > b) ? a : b;
  endfunction

  logic  accept;
  logic  win_first;
  logic  emit;
  data_t acc;
  data_t win_max;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  maxpool_win_ctl #(
    .LENY (LENY),
    .POOL (POOL)
  ) u_win_ctl (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .win_first (win_first),
    .emit      (emit)
  );

  // The first sample of a window must not be compared against a stale acc.
  assign win_max = win_first ? s_data_in : smax(acc, s_data_in);

  // ---- stage boundary: running max and output register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      m_data_out <= '0;
      m_valid    <= 1'b0;
    end else begin
      if (accept) begin
        acc <= win_max;
      end
      if (accept && emit) begin
        m_data_out <= win_max;
        m_valid    <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_1d_stream.sv
// Self-checking bench for maxpool_1d_stream; expectations adapt to MAXPOOL_PARTIAL_WIN_EN.
module tb_maxpool_1d_stream;
  import conv_pkg::*;

  localparam int LENY = DEF_LENY;
  localparam int POOL = DEF_POOL;
`ifdef MAXPOOL_PARTIAL_WIN_EN
  localparam bit PARTIAL = 1'b1;
`else
  localparam bit PARTIAL = 1'b0;
`endif

  logic    clk = 1'b0;
  logic    reset;
  sample_t s_data_in;
  logic    s_valid;
  logic    s_ready;
  sample_t m_data_out;
  logic    m_valid;
  logic    m_ready;

  int checks   = 0;
  int failures = 0;

  // Reference model state: pending output slot plus the samples of the open window.
  bit      exp_valid;
  sample_t exp_data;
  sample_t win_q[$];
  int      pos;
  int      model_results;
  int      dut_taken;
  int      accepted;
  bit      exp_sready;
  logic    sready_obs;

  always #5 clk = ~clk;

  maxpool_1d_stream dut (
    .clk        (clk),
    .reset      (reset),
    .s_data_in  (s_data_in),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data_out (m_data_out),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic sample_t qmax(input sample_t q[$]);
    sample_t m;
    m = q[0];
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  task automatic model_clear();
    exp_valid = 1'b0;
    exp_data  = '0;
    win_q.delete();
    pos = 0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    s_valid   = 1'b0;
    m_ready   = 1'b0;
    s_data_in = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // One clock of stimulus; advances the reference model across the edge.
  task automatic step(input bit sv, input int sd, input bit mr);
    bit acc_now;
    bit take;
    s_valid   = sv;
    s_data_in = sample_t'(sd);
    m_ready   = mr;
    #1;
    exp_sready = !exp_valid || mr;
    sready_obs = s_ready;
    acc_now    = sv && exp_sready;
    take       = exp_valid && mr;
    if (m_valid && m_ready) dut_taken++;
    @(posedge clk);
    if (take) exp_valid = 1'b0;
    if (acc_now) begin
      accepted++;
      win_q.push_back(sample_t'(sd));
      pos++;
      if (win_q.size() == POOL || pos == LENY) begin
        if (win_q.size() == POOL || PARTIAL) begin
          exp_valid = 1'b1;
          exp_data  = qmax(win_q);
          model_results++;
        end
        win_q.delete();
        if (pos == LENY) pos = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    s_valid   = 1'b1;
    s_data_in = 8'sd55;
    m_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_m_valid got=%b want=0", m_valid);
    end
    checks++;
    if (m_data_out !== 8'sd0) begin
      failures++;
      $display("FAIL reset_m_data got=%0d want=0", m_data_out);
    end
    reset   = 1'b0;
    s_valid = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_s_ready got=%b want=1", s_ready);
    end
  endtask

  task automatic test_frame();
    int d[10];
    int ed[10];
    bit ev[10];
    d  = '{3, 9, -2, 4, 7, 1, 0, 0, 0, 0};
    ev = '{0, 1, 0, 1, PARTIAL, 0, 1, 0, 1, PARTIAL};
    ed = '{0, 9, 0, 4, 7, 0, 1, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, d[i], 1'b1);
      checks++;
      if (sready_obs !== 1'b1) begin
        failures++;
        $display("FAIL frame_s_ready[%0d] got=%b want=1", i, sready_obs);
      end
      checks++;
      if (m_valid !== ev[i] || (ev[i] && m_data_out !== sample_t'(ed[i]))) begin
        failures++;
        $display("FAIL frame_out[%0d] got valid=%b data=%0d want valid=%b data=%0d",
                 i, m_valid, m_data_out, ev[i], ed[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1'b1, 3, 1'b1);
    step(1'b1, 9, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || m_data_out !== 8'sd9) begin
      failures++;
      $display("FAIL bp_first got valid=%b data=%0d want valid=1 data=9", m_valid, m_data_out);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, -2, 1'b0);
      checks++;
      if (sready_obs !== 1'b0) begin
        failures++;
        $display("FAIL bp_s_ready[%0d] got=%b want=0", i, sready_obs);
      end
      checks++;
      if (m_valid !== 1'b1 || m_data_out !== 8'sd9) begin
        failures++;
        $display("FAIL bp_hold[%0d] got valid=%b data=%0d want valid=1 data=9", i, m_valid, m_data_out);
      end
    end
    step(1'b1, -2, 1'b1);
    checks++;
    if (sready_obs !== 1'b1 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got s_ready=%b m_valid=%b want s_ready=1 m_valid=0", sready_obs, m_valid);
    end
    step(1'b1, 4, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || m_data_out !== 8'sd4) begin
      failures++;
      $display("FAIL bp_second got valid=%b data=%0d want valid=1 data=4", m_valid, m_data_out);
    end
    step(1'b1, 7, 1'b1);
    checks++;
    if (m_valid !== PARTIAL || (PARTIAL && m_data_out !== 8'sd7)) begin
      failures++;
      $display("FAIL bp_third got valid=%b data=%0d want valid=%b data=7", m_valid, m_data_out, PARTIAL);
    end
  endtask

  task automatic test_negative();
    int d[5];
    int ed[5];
    bit ev[5];
    d  = '{-128, -1, -5, -6, -128};
    ev = '{0, 1, 0, 1, PARTIAL};
    ed = '{0, -1, 0, -5, -128};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, d[i], 1'b1);
      checks++;
      if (m_valid !== ev[i] || (ev[i] && m_data_out !== sample_t'(ed[i]))) begin
        failures++;
        $display("FAIL neg_out[%0d] got valid=%b data=%0d want valid=%b data=%0d",
                 i, m_valid, m_data_out, ev[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ed[5];
    bit ev[5];
    ev = '{0, 1, 0, 1, PARTIAL};
    ed = '{0, 6, 0, 8, 9};
    do_reset();
    step(1'b1, 1, 1'b1);
    step(1'b1, 2, 1'b1);
    step(1'b1, 3, 1'b1);
    do_reset();
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_m_valid got=%b want=0", m_valid);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 5 + i, 1'b1);
      checks++;
      if (m_valid !== ev[i] || (ev[i] && m_data_out !== sample_t'(ed[i]))) begin
        failures++;
        $display("FAIL midreset_out[%0d] got valid=%b data=%0d want valid=%b data=%0d",
                 i, m_valid, m_data_out, ev[i], ed[i]);
      end
    end
  endtask

  task automatic test_random();
    int cyc;
    int want_cnt;
    bit sv;
    bit mr;
    int sd;
    do_reset();
    model_results = 0;
    dut_taken     = 0;
    accepted      = 0;
    cyc           = 0;
    while (accepted < 10000 && cyc < 60000) begin
      sv = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 3) != 0);
      sd = int'($urandom_range(0, 255)) - 128;
      step(sv, sd, mr);
      cyc++;
      checks++;
      if (sready_obs !== exp_sready) begin
        failures++;
        $display("FAIL rand_s_ready cyc=%0d got=%b want=%b", cyc, sready_obs, exp_sready);
      end
      checks++;
      if (m_valid !== exp_valid || (exp_valid && m_data_out !== exp_data)) begin
        failures++;
        $display("FAIL rand_out cyc=%0d got valid=%b data=%0d want valid=%b data=%0d",
                 cyc, m_valid, m_data_out, exp_valid, exp_data);
      end
    end
    checks++;
    if (accepted < 10000) begin
      failures++;
      $display("FAIL rand_budget accepted=%0d want=10000", accepted);
    end
    repeat (3) step(1'b0, 0, 1'b1);
    want_cnt = (10000 / LENY) * (PARTIAL ? (LENY + POOL - 1) / POOL : LENY / POOL);
    checks++;
    if (dut_taken !== want_cnt) begin
      failures++;
      $display("FAIL rand_count got=%0d want=%0d", dut_taken, want_cnt);
    end
    checks++;
    if (model_results !== want_cnt) begin
      failures++;
      $display("FAIL rand_model_count got=%0d want=%0d", model_results, want_cnt);
    end
  endtask

  initial begin
    reset     = 1'b1;
    s_valid   = 1'b0;
    s_data_in = '0;
    m_ready   = 1'b0;
    model_results = 0;
    dut_taken     = 0;
    accepted      = 0;
    model_clear();
    test_reset();
    test_frame();
    test_backpressure();
    test_negative();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maxpool_1d_stream.md
MAXPOOL_1D_STREAM -- requirements
Module: maxpool_1d_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning sample width in bits (signed two's complement).
REQ-002 SHALL have parameter LENY, default 5, meaning samples per frame from the upstream convolution stage.
REQ-003 SHALL have parameter POOL, default 2, meaning window size, with stride equal to POOL.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_data_in  input  WIDTH  signed input sample.
REQ-007 SHALL have port s_valid  input  1  upstream sample valid.
REQ-008 SHALL have port s_ready  output  1  block can accept a sample.
REQ-009 SHALL have port m_data_out  output  WIDTH  signed pooled result.
REQ-010 SHALL have port m_valid  output  1  m_data_out valid.
REQ-011 SHALL have port m_ready  input  1  downstream accepts the result.

Function
REQ-012 SHALL accept a sample on a rising edge when s_valid && s_ready, and a result when m_valid && m_ready.
REQ-013 SHALL drive s_ready = !m_valid || m_ready (combinational); while m_valid=1 and m_ready=0, no sample is accepted.
REQ-014 SHALL hold m_data_out and m_valid stable until the result is accepted.
REQ-015 SHALL keep a window counter win_cnt (0..POOL-1), a frame counter frm_cnt (0..LENY-1), and a running-max register acc.
REQ-016 SHALL, on the first accepted sample of a window, load acc with that sample; on each later sample, load acc with the signed max of acc and the sample.
REQ-017 SHALL close a window when the accepted sample has win_cnt==POOL-1 or frm_cnt==LENY-1.
REQ-018 SHALL, when a window closes, register the result max(acc, sample) into m_data_out and set m_valid on the next edge, giving 1-cycle latency from the closing sample.
REQ-019 SHALL clear win_cnt when a window closes, and clear frm_cnt after frm_cnt==LENY-1; frames are back-to-back with no idle cycle required.
REQ-020 SHALL allow a result to be accepted and a new closing sample to load in the same edge (full throughput); the new result replaces the old one and m_valid stays 1.
REQ-021 SHALL compare values as signed; for example, -128 < -1 < 0 < 127.
REQ-022 SHALL NOT saturate or modify values; the output equals one of the window's inputs.

Reset
REQ-023 SHALL, on reset, set m_valid=0, m_data_out=0, acc=0, win_cnt=0 and frm_cnt=0.
REQ-024 SHALL, on reset mid-window or mid-frame, discard all partial and pending results; the next accepted sample starts a new frame.
REQ-025 SHALL drive s_ready=1 in the cycle after reset is released.

Configuration
REQ-026 SHALL use macro MAXPOOL_PARTIAL_WIN_EN to control the trailing partial window.
REQ-027 SHALL, with MAXPOOL_PARTIAL_WIN_EN defined, emit the trailing partial window, giving ceil(LENY/POOL) results per frame (3 for the defaults).
REQ-028 SHALL, without MAXPOOL_PARTIAL_WIN_EN, consume the trailing partial-window samples without emitting a result, giving floor(LENY/POOL) results per frame (2 for the defaults); frm_cnt still wraps at LENY-1.
REQ-029 SHALL leave behaviour unaffected by the macro when LENY % POOL == 0.

Structure
REQ-030 SHALL import WIDTH, LENY and POOL defaults and typedef sample_t (logic signed [WIDTH-1:0]) from shared package conv_pkg.
REQ-031 SHALL size counters with $clog2 of POOL and LENY, each with a minimum of 1 bit, derived in conv_pkg.
REQ-032 SHALL implement win_cnt/frm_cnt and the window-close decode in one sub-module, maxpool_win_ctl, with the datapath in the top module.

Verification
REQ-033 SHALL cover: defaults with the macro defined, frame 3,9,-2,4,7 with continuous handshakes -> outputs 9,4,7, each 1 cycle after its closing sample.
REQ-034 SHALL cover: the same frame with the macro undefined -> outputs 9,4 only; the next frame 1,0,0,0,0 -> first output 1.
REQ-035 SHALL cover: m_ready=0 for 6 cycles after the first result -> m_data_out=9 held, s_ready=0, no sample lost; release -> remaining outputs 4,7.
REQ-036 SHALL cover: negative values -128,-1,-5,-6,-128 -> outputs -1,-5,-128 (macro defined).
REQ-037 SHALL cover: reset asserted after 3 samples of a frame -> m_valid=0; a new frame 5,6,7,8,9 -> outputs 6,8,9.
REQ-038 SHALL cover: random s_valid/m_ready over 10000 samples compared against a reference model -> zero mismatches and exact result count.
